vexu_sched: RTL and testbench

Parametrised issue/writeback scheduler for the vector execution unit. Buffers vector commands from the IDU in a small command queue and tracks pending vector-register writes in a scoreboard. Issues commands in order to NUM_UNIT functional units (VALU, VLSU, SHA, AES, …) over per-unit req/rdy handshakes. Arbitrates unit writebacks round-robin onto the single VRF write port, so long-latency crypto and memory units overlap with ALU work without RAW/WAR/WAW hazards.

---
 rtl/scr1_vexu_isa_pkg.sv | 14 +
 rtl/scr1_vexu_pkg.sv | 24 ++
 rtl/vexu_wb_arb.sv | 60 ++++++
 rtl/vexu_sched.sv | 207 ++++++++++++++++++++
 tb/tb_vexu_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scr1_vexu_isa_pkg.sv
// Purpose : vector command format shared between the IDU and the vector execution unit.
// Latency : n/a (type definitions only).
// Backpressure: n/a.
package scr1_vexu_isa_pkg;

    typedef struct packed {
        logic [7:0] opcode;
        logic [4:0] rs3_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rs1_addr;
        logic [4:0] rd_addr;
    } type_scr1_vexu_cmd_s;

endpackage

// File: rtl/scr1_vexu_pkg.sv
// Purpose : vexu scheduler types (command queue entry) and constants.
// Latency : n/a (type definitions only).
// Backpressure: n/a.
package scr1_vexu_pkg;

    import scr1_vexu_isa_pkg::*;

    localparam int SCR1_VREG_NUM    = 32;
    // Unit index is stored wider than $clog2(NUM_UNIT) so the entry type does not
    // depend on a module parameter; out-of-range indices still survive intact.
    localparam int SCR1_VEXU_UNIT_W = 8;

    typedef struct packed {
        type_scr1_vexu_cmd_s         cmd;
        logic [SCR1_VEXU_UNIT_W-1:0] unit;
        logic                        rd_we;
    } type_scr1_vexu_qent_s;

    function automatic logic [SCR1_VREG_NUM-1:0] vreg_onehot(input logic [4:0] addr);
        vreg_onehot       = '0;
        vreg_onehot[addr] = 1'b1;
    endfunction

endpackage

// File: rtl/vexu_wb_arb.sv
// Purpose : round-robin arbiter, one-hot grant starting the search at pointer p.
// Latency : grant is combinational from req; pointer moves to grant+1 on the edge when adv=1.
// Backpressure: none; requesters hold req until granted.
// Ports   : clk, rst (async active-high), req[NUM_UNIT], adv, gnt[NUM_UNIT] one-hot.
module vexu_wb_arb #(
    parameter int NUM_UNIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_UNIT-1:0] req,
    input  logic                adv,
    output logic [NUM_UNIT-1:0] gnt
);

    localparam int UW = $clog2(NUM_UNIT);

    logic [UW-1:0]       ptr_q, ptr_d;
    logic [NUM_UNIT-1:0] gnt_hi, gnt_lo;
    logic                hit_hi, hit_lo;

    // Two priority passes: lowest requester at or above the pointer, else the
    // lowest requester overall (wrapped search).
    always_comb begin
        gnt_hi = '0;
        gnt_lo = '0;
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        for (int j = 0; j < NUM_UNIT; j++) begin
            if (req[j] && (j >= int'(ptr_q)) && !hit_hi) begin
                gnt_hi[j] = 1'b1;
                hit_hi    = 1'b1;
            end
            if (req[j] && !hit_lo) begin
                gnt_lo[j] = 1'b1;
                hit_lo    = 1'b1;
            end
        end
        gnt = hit_hi ? gnt_hi : gnt_lo;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            for (int j = 0; j < NUM_UNIT; j++) begin
                if (gnt[j]) begin
                    ptr_d = (j == NUM_UNIT - 1) ? '0 : UW'(j + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/vexu_sched.sv
// Purpose : in-order vector command issue with a 32-bit write scoreboard and
//           round-robin writeback onto the single VRF write port.
// Latency : command pushed at edge N may issue in cycle N+1; writeback ack and VRF
//           write are combinational in the cycle of the granted wb_req.
// Backpressure: vexu2idu_rdy low while the queue is full; the head waits on a
//           scoreboard hazard or unit rdy; units hold wb_req until acked.
// Option  : SCR1_VEXU_WB_BYPASS_EN - hazard check sees this cycle's writeback
//           clear, so a released head issues in the ack cycle.
// Ports   : clk/rst; idu2vexu_* command in, vexu2idu_rdy/busy out;
//           vexu2unit_req/cmd issue out, unit2vexu_rdy in; unit2vexu_wb_* results
//           in, vexu2unit_wb_ack out; vexu2vrf_rd_* VRF write port out.
module vexu_sched
    import scr1_vexu_isa_pkg::*;
    import scr1_vexu_pkg::*;
#(
    parameter  int LANE       = 8,
    parameter  int NUM_UNIT   = 4,
    parameter  int CMDQ_DEPTH = 4,
    localparam int UW         = $clog2(NUM_UNIT)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               idu2vexu_req,
    input  type_scr1_vexu_cmd_s                idu2vexu_cmd,
    input  logic [UW-1:0]                      idu2vexu_unit,
    input  logic                               idu2vexu_rd_we,
    output logic                               vexu2idu_rdy,
    output logic                               vexu2idu_busy,
    output logic [NUM_UNIT-1:0]                vexu2unit_req,
    output type_scr1_vexu_cmd_s                vexu2unit_cmd,
    input  logic [NUM_UNIT-1:0]                unit2vexu_rdy,
    input  logic [NUM_UNIT-1:0]                unit2vexu_wb_req,
    input  logic [NUM_UNIT-1:0][4:0]           unit2vexu_wb_addr,
    input  logic [NUM_UNIT-1:0][LANE-1:0]      unit2vexu_wb_mask,
    input  logic [NUM_UNIT-1:0][LANE-1:0][31:0] unit2vexu_wb_data,
    output logic [NUM_UNIT-1:0]                vexu2unit_wb_ack,
    output logic [4:0]                         vexu2vrf_rd_addr,
    output logic [LANE-1:0]                    vexu2vrf_rd_wreq,
    output logic [LANE-1:0][31:0]              vexu2vrf_rd_wdata
);

    localparam int QW = $clog2(CMDQ_DEPTH);
    localparam int CW = QW + 1;

    // Command queue state
    type_scr1_vexu_qent_s      cmdq_q [CMDQ_DEPTH];
    logic [QW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [QW-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    // Scoreboard and VRF hold registers
    logic [SCR1_VREG_NUM-1:0]  sb_q, sb_d;
    logic [4:0]                rd_addr_q, rd_addr_d;
    logic [LANE-1:0][31:0]     rd_wdata_q, rd_wdata_d;

    type_scr1_vexu_qent_s      push_ent, head;
    logic                      q_full, head_vld;
    logic                      push, pop, issue, drop;
    logic [NUM_UNIT-1:0]       unit_oh;
    logic                      unit_ok, unit_rdy, hazard;
    logic [SCR1_VREG_NUM-1:0]  sb_eff, sb_set, sb_clr;

    logic [NUM_UNIT-1:0]       wb_gnt;
    logic                      wb_any;
    logic [4:0]                wb_addr_sel;
    logic [LANE-1:0]           wb_mask_sel;
    logic [LANE-1:0][31:0]     wb_data_sel;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    // Full is judged on the registered count: a pop in the same cycle does
    // not open a slot for a push.
    assign q_full   = (cnt_q == CW'(CMDQ_DEPTH));
    assign head_vld = (cnt_q != '0);
    assign head     = cmdq_q[rd_ptr_q];
    assign push     = idu2vexu_req & ~q_full;

    assign push_ent = '{cmd:   idu2vexu_cmd,
                        unit:  {{(SCR1_VEXU_UNIT_W - UW){1'b0}}, idu2vexu_unit},
                        rd_we: idu2vexu_rd_we};

    always_ff @(posedge clk) begin
        if (push) begin
            cmdq_q[wr_ptr_q] <= push_ent;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Head decode and hazard check
    // ------------------------------------------------------------------
    // An index with no matching unit leaves unit_oh all-zero; such a head is
    // discarded without issue.
    always_comb begin
        unit_oh = '0;
        for (int u = 0; u < NUM_UNIT; u++) begin
            unit_oh[u] = (head.unit == SCR1_VEXU_UNIT_W'(u));
        end
    end

    assign unit_ok  = |unit_oh;
    assign unit_rdy = |(unit_oh & unit2vexu_rdy);

    assign sb_clr = wb_any ? vreg_onehot(wb_addr_sel) : '0;

`ifdef SCR1_VEXU_WB_BYPASS_EN
    assign sb_eff = sb_q & ~sb_clr;
`else
    assign sb_eff = sb_q;
`endif

    assign hazard = sb_eff[head.cmd.rs1_addr]
                  | sb_eff[head.cmd.rs2_addr]
                  | sb_eff[head.cmd.rs3_addr]
                  | (head.rd_we & sb_eff[head.cmd.rd_addr]);

    assign issue = head_vld & unit_ok & ~hazard & unit_rdy;
    assign drop  = head_vld & ~unit_ok;
    assign pop   = issue | drop;

    assign vexu2unit_req = (head_vld & ~hazard) ? unit_oh : '0;
    assign vexu2unit_cmd = head.cmd;

    assign sb_set = (issue & head.rd_we) ? vreg_onehot(head.cmd.rd_addr) : '0;

    // Set is applied after clear so a same-cycle set of a released register wins.
    assign sb_d = (sb_q & ~sb_clr) | sb_set;

    // ------------------------------------------------------------------
    // Writeback arbitration onto the VRF port
    // ------------------------------------------------------------------
    vexu_wb_arb #(
        .NUM_UNIT (NUM_UNIT)
    ) u_wb_arb (
        .clk (clk),
        .rst (rst),
        .req (unit2vexu_wb_req),
        .adv (wb_any),
        .gnt (wb_gnt)
    );

    always_comb begin
        wb_addr_sel = '0;
        wb_mask_sel = '0;
        wb_data_sel = '0;
        for (int u = 0; u < NUM_UNIT; u++) begin
            if (wb_gnt[u]) begin
                wb_addr_sel = unit2vexu_wb_addr[u];
                wb_mask_sel = unit2vexu_wb_mask[u];
                wb_data_sel = unit2vexu_wb_data[u];
            end
        end
    end

    assign wb_any = |wb_gnt;

    // Address and data keep showing the last granted write when idle.
    assign rd_addr_d  = wb_any ? wb_addr_sel : rd_addr_q;
    assign rd_wdata_d = wb_any ? wb_data_sel : rd_wdata_q;

    assign vexu2unit_wb_ack  = wb_gnt;
    assign vexu2vrf_rd_addr  = rd_addr_d;
    assign vexu2vrf_rd_wdata = rd_wdata_d;
    assign vexu2vrf_rd_wreq  = wb_any ? wb_mask_sel : '0;

    assign vexu2idu_rdy  = ~q_full;
    assign vexu2idu_busy = head_vld | (|sb_q);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            sb_q       <= '0;
            rd_addr_q  <= '0;
            rd_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            sb_q       <= sb_d;
            rd_addr_q  <= rd_addr_d;
            rd_wdata_q <= rd_wdata_d;
        end
    end

endmodule

// File: tb/tb_vexu_sched.sv
`timescale 1ns/1ps
module tb_vexu_sched;
    import scr1_vexu_isa_pkg::*;

    localparam int LANE = 8;
    localparam int NU   = 4;
    localparam int QD   = 4;
`ifdef SCR1_VEXU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance, NUM_UNIT = 4
    logic                 idu_req, idu_we, idu_rdy, busy;
    type_scr1_vexu_cmd_s  idu_cmd, u_cmd;
    logic [1:0]           idu_unit;
    logic [3:0]           u_req, u_rdy, wb_req, wb_ack;
    logic [3:0][4:0]      wb_addr;
    logic [3:0][7:0]      wb_mask;
    logic [3:0][7:0][31:0] wb_data;
    logic [4:0]           vrf_addr;
    logic [7:0]           vrf_wreq;
    logic [7:0][31:0]     vrf_wdata;

    // Second instance, NUM_UNIT = 3 (non-power-of-two)
    logic                 d3_req, d3_we, d3_rdy, d3_busy;
    type_scr1_vexu_cmd_s  d3_cmd, d3_ucmd;
    logic [1:0]           d3_unit;
    logic [2:0]           d3_ureq, d3_urdy, d3_wbreq, d3_wback;
    logic [2:0][4:0]      d3_wbaddr;
    logic [2:0][7:0]      d3_wbmask;
    logic [2:0][7:0][31:0] d3_wbdata;
    logic [4:0]           d3_vaddr;
    logic [7:0]           d3_vwreq;
    logic [7:0][31:0]     d3_vwdata;

    int vec_cnt = 0;
    int err_cnt = 0;

    vexu_sched #(.LANE(LANE), .NUM_UNIT(NU), .CMDQ_DEPTH(QD)) dut (
        .clk(clk), .rst(rst),
        .idu2vexu_req(idu_req), .idu2vexu_cmd(idu_cmd), .idu2vexu_unit(idu_unit),
        .idu2vexu_rd_we(idu_we), .vexu2idu_rdy(idu_rdy), .vexu2idu_busy(busy),
        .vexu2unit_req(u_req), .vexu2unit_cmd(u_cmd), .unit2vexu_rdy(u_rdy),
        .unit2vexu_wb_req(wb_req), .unit2vexu_wb_addr(wb_addr),
        .unit2vexu_wb_mask(wb_mask), .unit2vexu_wb_data(wb_data),
        .vexu2unit_wb_ack(wb_ack), .vexu2vrf_rd_addr(vrf_addr),
        .vexu2vrf_rd_wreq(vrf_wreq), .vexu2vrf_rd_wdata(vrf_wdata)
    );

    vexu_sched #(.LANE(LANE), .NUM_UNIT(3), .CMDQ_DEPTH(QD)) dut3 (
        .clk(clk), .rst(rst),
        .idu2vexu_req(d3_req), .idu2vexu_cmd(d3_cmd), .idu2vexu_unit(d3_unit),
        .idu2vexu_rd_we(d3_we), .vexu2idu_rdy(d3_rdy), .vexu2idu_busy(d3_busy),
        .vexu2unit_req(d3_ureq), .vexu2unit_cmd(d3_ucmd), .unit2vexu_rdy(d3_urdy),
        .unit2vexu_wb_req(d3_wbreq), .unit2vexu_wb_addr(d3_wbaddr),
        .unit2vexu_wb_mask(d3_wbmask), .unit2vexu_wb_data(d3_wbdata),
        .vexu2unit_wb_ack(d3_wback), .vexu2vrf_rd_addr(d3_vaddr),
        .vexu2vrf_rd_wreq(d3_vwreq), .vexu2vrf_rd_wdata(d3_vwdata)
    );

    task automatic idle_inputs();
        idu_req = 0; idu_cmd = '0; idu_unit = 0; idu_we = 0; u_rdy = 0;
        wb_req = 0; wb_addr = '0; wb_mask = '0; wb_data = '0;
        d3_req = 0; d3_cmd = '0; d3_unit = 0; d3_we = 0; d3_urdy = 0;
        d3_wbreq = 0; d3_wbaddr = '0; d3_wbmask = '0; d3_wbdata = '0;
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        vec_cnt++; if (idu_rdy !== 1'b1) begin err_cnt++; $display("FAIL reset_rdy got %0b want 1", idu_rdy); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %0b want 0", busy); end
        vec_cnt++; if (u_req !== 4'b0) begin err_cnt++; $display("FAIL reset_unit_req got %b want 0000", u_req); end
        vec_cnt++; if (wb_ack !== 4'b0) begin err_cnt++; $display("FAIL reset_wb_ack got %b want 0000", wb_ack); end
        vec_cnt++; if (vrf_wreq !== 8'h00) begin err_cnt++; $display("FAIL reset_wreq got %h want 00", vrf_wreq); end
        vec_cnt++; if (vrf_addr !== 5'd0) begin err_cnt++; $display("FAIL reset_rd_addr got %0d want 0", vrf_addr); end
        vec_cnt++; if (vrf_wdata !== '0) begin err_cnt++; $display("FAIL reset_rd_wdata got %h want 0", vrf_wdata); end
        vec_cnt++; if (d3_rdy !== 1'b1 || d3_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_dut3 got rdy=%0b busy=%0b want 1/0", d3_rdy, d3_busy); end
        next_cycle();
    endtask

    // Fill the queue toward a stalled unit 0; the 5th command must be refused.
    task automatic test_fill();
        int issues;
        do_reset();
        idu_req = 1; idu_unit = 0; idu_we = 0; u_rdy = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            idu_cmd = '0;
            idu_cmd.opcode = 8'(i + 1);
            @(negedge clk);
            vec_cnt++; if (idu_rdy !== (i < 4)) begin err_cnt++; $display("FAIL fill_rdy[%0d] got %0b want %0b", i, idu_rdy, (i < 4)); end
            vec_cnt++; if (u_req !== ((i >= 1) ? 4'b0001 : 4'b0000)) begin err_cnt++; $display("FAIL fill_unit_req[%0d] got %b", i, u_req); end
            next_cycle();
        end
        idu_req = 0; u_rdy = 4'b0001; issues = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (u_req[0]) begin
                issues++;
                vec_cnt++; if (u_cmd.opcode !== 8'(issues)) begin err_cnt++; $display("FAIL fill_order got op %0d want %0d", u_cmd.opcode, issues); end
            end
            next_cycle();
        end
        vec_cnt++; if (issues != 4) begin err_cnt++; $display("FAIL fill_issue_count got %0d want 4", issues); end
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL fill_busy_end got %0b want 0", busy); end
        next_cycle();
    endtask

    // RAW: B reads v3 written by A on unit 2; B waits for the v3 writeback.
    task automatic test_raw();
        do_reset();
        u_rdy = 4'b1111;
        idu_req = 1; idu_cmd = '0; idu_cmd.rd_addr = 5'd3; idu_unit = 2; idu_we = 1;
        next_cycle();
        idu_cmd = '0; idu_cmd.rs1_addr = 5'd3; idu_unit = 0; idu_we = 0;
        @(negedge clk);
        vec_cnt++; if (u_req !== 4'b0100) begin err_cnt++; $display("FAIL raw_issue_a got %b want 0100", u_req); end
        next_cycle();
        idu_req = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vec_cnt++; if (u_req !== 4'b0000) begin err_cnt++; $display("FAIL raw_blocked[%0d] got %b want 0000", c, u_req); end
            next_cycle();
        end
        wb_req = 4'b0100; wb_addr[2] = 5'd3; wb_mask[2] = 8'hFF;
        for (int l = 0; l < LANE; l++) wb_data[2][l] = 32'hA000_0000 + l;
        @(negedge clk);
        vec_cnt++; if (wb_ack !== 4'b0100) begin err_cnt++; $display("FAIL raw_ack got %b want 0100", wb_ack); end
        vec_cnt++; if (vrf_addr !== 5'd3 || vrf_wreq !== 8'hFF) begin err_cnt++; $display("FAIL raw_vrf got addr=%0d wreq=%h want 3/ff", vrf_addr, vrf_wreq); end
        vec_cnt++; if (u_req !== (BYP ? 4'b0001 : 4'b0000)) begin err_cnt++; $display("FAIL raw_ack_cycle_req got %b want %b", u_req, (BYP ? 4'b0001 : 4'b0000)); end
        next_cycle();
        wb_req = 0;
        @(negedge clk);
        vec_cnt++; if (u_req !== (BYP ? 4'b0000 : 4'b0001)) begin err_cnt++; $display("FAIL raw_after_ack_req got %b want %b", u_req, (BYP ? 4'b0000 : 4'b0001)); end
        vec_cnt++; if (busy !== !BYP) begin err_cnt++; $display("FAIL raw_after_ack_busy got %0b want %0b", busy, !BYP); end
        next_cycle();
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL raw_busy_end got %0b want 0", busy); end
        next_cycle();
    endtask

    // Units 0, 1, 3 request together with p=0: grants 0, 1, 3; then p is back at 0.
    task automatic test_rr();
        logic [3:0] exp_ack [3];
        logic [7:0] exp_mask [3];
        int         exp_u [3];
        exp_ack = '{4'b0001, 4'b0010, 4'b1000};
        exp_mask = '{8'h0F, 8'hA5, 8'h3C};
        exp_u = '{0, 1, 3};
        do_reset();
        wb_req = 4'b1011;
        wb_addr[0] = 5'd1; wb_addr[1] = 5'd2; wb_addr[3] = 5'd4;
        wb_mask[0] = 8'h0F; wb_mask[1] = 8'hA5; wb_mask[3] = 8'h3C;
        for (int u = 0; u < 4; u++)
            for (int l = 0; l < LANE; l++) wb_data[u][l] = 32'h1000_0000 * (u + 1) + l;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec_cnt++; if (wb_ack !== exp_ack[k]) begin err_cnt++; $display("FAIL rr_ack[%0d] got %b want %b", k, wb_ack, exp_ack[k]); end
            vec_cnt++; if (vrf_wreq !== exp_mask[k]) begin err_cnt++; $display("FAIL rr_wreq[%0d] got %h want %h", k, vrf_wreq, exp_mask[k]); end
            vec_cnt++; if (vrf_wdata[5] !== 32'h1000_0000 * (exp_u[k] + 1) + 5) begin err_cnt++; $display("FAIL rr_wdata[%0d] got %h", k, vrf_wdata[5]); end
            next_cycle();
            wb_req[exp_u[k]] = 1'b0;
        end
        wb_req = 4'b0101;
        @(negedge clk);
        vec_cnt++; if (wb_ack !== 4'b0001) begin err_cnt++; $display("FAIL rr_ptr_wrap got %b want 0001", wb_ack); end
        next_cycle();
        wb_req = 4'b0000;
        @(negedge clk);
        vec_cnt++; if (wb_ack !== 4'b0 || vrf_wreq !== 8'h00) begin err_cnt++; $display("FAIL rr_idle got ack=%b wreq=%h want 0/0", wb_ack, vrf_wreq); end
        vec_cnt++; if (vrf_addr !== 5'd1 || vrf_wdata[0] !== 32'h1000_0000) begin err_cnt++; $display("FAIL rr_hold got addr=%0d d0=%h want 1/10000000", vrf_addr, vrf_wdata[0]); end
        next_cycle();
    endtask

    // Zero-mask writeback still releases v5.
    task automatic test_zero_mask();
        do_reset();
        u_rdy = 4'b0011;
        idu_req = 1; idu_cmd = '0; idu_cmd.rd_addr = 5'd5; idu_unit = 1; idu_we = 1;
        next_cycle();
        idu_req = 0;
        next_cycle();
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL zm_busy_pending got %0b want 1", busy); end
        next_cycle();
        wb_req = 4'b0010; wb_addr[1] = 5'd5; wb_mask[1] = 8'h00; wb_data[1] = '1;
        @(negedge clk);
        vec_cnt++; if (wb_ack !== 4'b0010) begin err_cnt++; $display("FAIL zm_ack got %b want 0010", wb_ack); end
        vec_cnt++; if (vrf_wreq !== 8'h00) begin err_cnt++; $display("FAIL zm_wreq got %h want 00", vrf_wreq); end
        next_cycle();
        wb_req = 0;
        idu_req = 1; idu_cmd = '0; idu_cmd.rs1_addr = 5'd5; idu_unit = 0; idu_we = 0;
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL zm_busy_clear got %0b want 0", busy); end
        next_cycle();
        idu_req = 0;
        @(negedge clk);
        vec_cnt++; if (u_req !== 4'b0001) begin err_cnt++; $display("FAIL zm_reader_issue got %b want 0001", u_req); end
        next_cycle();
    endtask

    // NUM_UNIT=3 instance: unit index 3 is discarded in one cycle.
    task automatic test_bad_unit();
        do_reset();
        d3_urdy = 3'b111;
        d3_req = 1; d3_cmd = '0; d3_cmd.rd_addr = 5'd9; d3_unit = 2'd3; d3_we = 1;
        next_cycle();
        d3_req = 0;
        @(negedge clk);
        vec_cnt++; if (d3_ureq !== 3'b000) begin err_cnt++; $display("FAIL bad_unit_req got %b want 000", d3_ureq); end
        vec_cnt++; if (d3_busy !== 1'b1) begin err_cnt++; $display("FAIL bad_unit_busy_head got %0b want 1", d3_busy); end
        next_cycle();
        d3_req = 1; d3_cmd = '0; d3_cmd.rs1_addr = 5'd9; d3_unit = 2'd1; d3_we = 0;
        @(negedge clk);
        vec_cnt++; if (d3_busy !== 1'b0) begin err_cnt++; $display("FAIL bad_unit_popped got busy=%0b want 0", d3_busy); end
        next_cycle();
        d3_req = 0;
        @(negedge clk);
        vec_cnt++; if (d3_ureq !== 3'b010) begin err_cnt++; $display("FAIL bad_unit_sb_untouched got %b want 010", d3_ureq); end
        next_cycle();
    endtask

    // Reset with two commands queued and v7 pending.
    task automatic test_reset_mid();
        do_reset();
        u_rdy = 4'b0010;
        idu_req = 1; idu_cmd = '0; idu_cmd.rd_addr = 5'd7; idu_unit = 1; idu_we = 1;
        next_cycle();
        idu_cmd = '0; idu_cmd.opcode = 8'd1; idu_unit = 0; idu_we = 0;
        next_cycle();
        idu_cmd.opcode = 8'd2;
        next_cycle();
        idu_req = 0;
        wb_req = 4'b1000; wb_addr[3] = 5'd20; wb_mask[3] = 8'hFF;
        @(negedge clk);
        vec_cnt++; if (busy !== 1'b1 || u_req !== 4'b0001) begin err_cnt++; $display("FAIL rmid_pre got busy=%0b req=%b want 1/0001", busy, u_req); end
        vec_cnt++; if (wb_ack !== 4'b1000) begin err_cnt++; $display("FAIL rmid_pre_ack got %b want 1000", wb_ack); end
        #2;
        rst = 1'b1; wb_req = 4'b0000;
        #1;
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_async_busy got %0b want 0", busy); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++; if (idu_rdy !== 1'b1 || busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_post got rdy=%0b busy=%0b want 1/0", idu_rdy, busy); end
        vec_cnt++; if (u_req !== 4'b0 || wb_ack !== 4'b0 || vrf_wreq !== 8'h0) begin err_cnt++; $display("FAIL rmid_post_outs got req=%b ack=%b wreq=%h want 0", u_req, wb_ack, vrf_wreq); end
        next_cycle();
    endtask

    typedef struct {
        type_scr1_vexu_cmd_s cmd;
        int                  unit;
        bit                  we;
    } ent_t;

    // Random traffic checked every cycle against a queue/scoreboard model.
    task automatic test_random();
        ent_t              mq[$];
        ent_t              e;
        bit [31:0]         msb, clr, sbe, set;
        int                mp, g, idx;
        logic [4:0]        laddr, exp_addr;
        logic [7:0][31:0]  ldata, exp_data;
        bit                wbv [4];
        logic [7:0]        wmask [4];
        logic [7:0][31:0]  wdat [4];
        int                pa [4][32];
        int                ph [4];
        int                pc [4];
        bit                haz, iss, exp_rdy, exp_busy;
        logic [3:0]        exp_req, exp_ack;
        logic [7:0]        exp_wreq;

        do_reset();
        msb = 0; mp = 0; laddr = 0; ldata = '0;
        for (int u = 0; u < 4; u++) begin wbv[u] = 0; ph[u] = 0; pc[u] = 0; wmask[u] = 0; wdat[u] = '0; end

        for (int c = 0; c < 1500; c++) begin
            idu_req = ($urandom_range(2) != 0);
            idu_cmd.opcode   = 8'($urandom);
            idu_cmd.rs1_addr = 5'($urandom_range(7));
            idu_cmd.rs2_addr = 5'($urandom_range(7));
            idu_cmd.rs3_addr = 5'($urandom_range(7));
            idu_cmd.rd_addr  = 5'($urandom_range(7));
            idu_unit = 2'($urandom_range(3));
            idu_we   = 1'($urandom_range(1));
            u_rdy    = 4'($urandom);
            for (int u = 0; u < 4; u++) begin
                if (!wbv[u] && pc[u] > 0 && $urandom_range(2) == 0) begin
                    wbv[u]   = 1;
                    wmask[u] = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
                    for (int l = 0; l < LANE; l++) wdat[u][l] = $urandom;
                end
                wb_req[u]  = wbv[u];
                wb_addr[u] = wbv[u] ? 5'(pa[u][ph[u]]) : 5'd0;
                wb_mask[u] = wbv[u] ? wmask[u] : 8'h00;
                wb_data[u] = wbv[u] ? wdat[u] : '0;
            end

            @(negedge clk);
            g = -1;
            for (int i = 0; i < 4; i++) begin
                idx = (mp + i) % 4;
                if (g < 0 && wbv[idx]) g = idx;
            end
            clr = (g >= 0) ? (32'd1 << pa[g][ph[g]]) : 32'd0;
            sbe = BYP ? (msb & ~clr) : msb;
            exp_req = 0; iss = 0; set = 0;
            if (mq.size() > 0) begin
                e = mq[0];
                haz = sbe[e.cmd.rs1_addr] | sbe[e.cmd.rs2_addr] | sbe[e.cmd.rs3_addr] | (e.we & sbe[e.cmd.rd_addr]);
                if (!haz) exp_req[e.unit] = 1'b1;
                iss = !haz && u_rdy[e.unit];
                vec_cnt++; if (u_cmd !== e.cmd) begin err_cnt++; $display("FAIL rnd_cmd c=%0d got %h want %h", c, u_cmd, e.cmd); end
            end
            exp_rdy  = (mq.size() < QD);
            exp_busy = (mq.size() > 0) || (msb != 0);
            exp_ack  = (g >= 0) ? 4'(1 << g) : 4'b0;
            exp_wreq = (g >= 0) ? wmask[g] : 8'h00;
            exp_addr = (g >= 0) ? 5'(pa[g][ph[g]]) : laddr;
            exp_data = (g >= 0) ? wdat[g] : ldata;

            vec_cnt++; if (idu_rdy !== exp_rdy) begin err_cnt++; $display("FAIL rnd_rdy c=%0d got %0b want %0b", c, idu_rdy, exp_rdy); end
            vec_cnt++; if (busy !== exp_busy) begin err_cnt++; $display("FAIL rnd_busy c=%0d got %0b want %0b", c, busy, exp_busy); end
            vec_cnt++; if (u_req !== exp_req) begin err_cnt++; $display("FAIL rnd_unit_req c=%0d got %b want %b", c, u_req, exp_req); end
            vec_cnt++; if (wb_ack !== exp_ack) begin err_cnt++; $display("FAIL rnd_wb_ack c=%0d got %b want %b", c, wb_ack, exp_ack); end
            vec_cnt++; if (vrf_wreq !== exp_wreq) begin err_cnt++; $display("FAIL rnd_wreq c=%0d got %h want %h", c, vrf_wreq, exp_wreq); end
            vec_cnt++; if (vrf_addr !== exp_addr) begin err_cnt++; $display("FAIL rnd_rd_addr c=%0d got %0d want %0d", c, vrf_addr, exp_addr); end
            vec_cnt++; if (vrf_wdata !== exp_data) begin err_cnt++; $display("FAIL rnd_rd_wdata c=%0d got %h want %h", c, vrf_wdata, exp_data); end

            if (iss) begin
                if (e.we) begin
                    set = 32'd1 << e.cmd.rd_addr;
                    pa[e.unit][(ph[e.unit] + pc[e.unit]) % 32] = int'(e.cmd.rd_addr);
                    pc[e.unit]++;
                end
                void'(mq.pop_front());
            end
            if (idu_req && exp_rdy) mq.push_back('{idu_cmd, int'(idu_unit), idu_we});
            msb = (msb & ~clr) | set;
            if (g >= 0) begin
                mp = (g + 1) % 4;
                laddr = exp_addr;
                ldata = exp_data;
                wbv[g] = 0;
                ph[g] = (ph[g] + 1) % 32;
                pc[g]--;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fill();
        test_raw();
        test_rr();
        test_zero_mask();
        test_bad_unit();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
